// File: rtl/compare_scan_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | compare_scan_ctrl_pkg : FSM state encodings and comparator result codes  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package compare_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CMP_TRUE  = 8'hFF;
  localparam logic [7:0] CMP_FALSE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/compare_scan_ctrl_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | compare_scan_ctrl_cmp : 8-bit combinational comparator, 8'hFF when a>=b  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module compare_scan_ctrl_cmp
  import compare_scan_ctrl_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out
);

  always_comb begin
    out = (a >= b) ? CMP_TRUE : CMP_FALSE;
  end

endmodule
`default_nettype wire

// File: rtl/compare_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | compare_scan_ctrl : scans buffer entries 0..len-1 for max (and min when  |
// | MIN_TRACK_EN is defined) using the shared comparator.   Rev 1.0          |
// +--------------------------------------------------------------------------+
module compare_scan_ctrl
  import compare_scan_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          empty,
  output logic [7:0]    max_val,
  output logic [AW-1:0] max_idx
`ifdef MIN_TRACK_EN
  ,
  output logic [7:0]    min_val,
  output logic [AW-1:0] min_idx
`endif
);

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic [AW-1:0] last;
  logic [AW-1:0] last_nxt;
  logic [7:0]    rd_data;
  logic [7:0]    max_cmp;
  logic          len_zero;

  assign rd_data  = mem[idx];
  assign len_zero = (len == '0);

  // Oversized lengths clamp to the full buffer; last holds the final index.
  always_comb begin
    last_nxt = '0;
    if (len >= (AW+1)'(DEPTH)) begin
      last_nxt = AW'(DEPTH - 1);
    end else begin
      last_nxt = len[AW-1:0] - AW'(1);
    end
  end

  compare_scan_ctrl_cmp u_cmp_max (
    .a   (rd_data),
    .b   (max_val),
    .out (max_cmp)
  );

`ifdef MIN_TRACK_EN
  logic [7:0] min_cmp;

  compare_scan_ctrl_cmp u_cmp_min (
    .a   (min_val),
    .b   (rd_data),
    .out (min_cmp)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = len_zero ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (idx == last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      idx     <= '0;
      last    <= '0;
      empty   <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
`ifdef MIN_TRACK_EN
      min_val <= '0;
      min_idx <= '0;
`endif
    end else begin
      // The buffer is frozen while a scan is walking it.
      if (wr_en && (state != S_SCAN)) begin
        mem[wr_addr] <= wr_data;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            idx   <= '0;
            last  <= last_nxt;
            empty <= len_zero;
            if (len_zero) begin
              max_val <= '0;
              max_idx <= '0;
`ifdef MIN_TRACK_EN
              min_val <= '0;
              min_idx <= '0;
`endif
            end
          end
        end
        S_SCAN: begin
          if (idx == '0) begin
            max_val <= rd_data;
            max_idx <= idx;
`ifdef MIN_TRACK_EN
            min_val <= rd_data;
            min_idx <= idx;
`endif
          end else begin
            if (max_cmp == CMP_TRUE) begin
              max_val <= rd_data;
              max_idx <= idx;
            end
`ifdef MIN_TRACK_EN
            if (min_cmp == CMP_TRUE) begin
              min_val <= rd_data;
              min_idx <= idx;
            end
`endif
          end
          if (idx == last) begin
            idx <= '0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compare_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_compare_scan_ctrl : scoreboard bench for compare_scan_ctrl            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_compare_scan_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          empty;
  logic [7:0]    max_val;
  logic [AW-1:0] max_idx;
`ifdef MIN_TRACK_EN
  logic [7:0]    min_val;
  logic [AW-1:0] min_idx;
`endif

  compare_scan_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .empty   (empty),
    .max_val (max_val),
    .max_idx (max_idx)
`ifdef MIN_TRACK_EN
    ,
    .min_val (min_val),
    .min_idx (min_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    v;
    logic [AW-1:0] i;
    logic          e;
    logic [7:0]    mn;
    logic [AW-1:0] mi;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [DEPTH];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t r;
    int   ne;
    ne = (n > DEPTH) ? DEPTH : n;
    r  = '0;
    if (ne == 0) begin
      r.e = 1'b1;
    end else begin
      r.v  = mdl[0];
      r.mn = mdl[0];
      for (int j = 1; j < ne; j++) begin
        if (mdl[j] >= r.v) begin
          r.v = mdl[j];
          r.i = AW'(j);
        end
        if (r.mn >= mdl[j]) begin
          r.mn = mdl[j];
          r.mi = AW'(j);
        end
      end
    end
    return r;
  endfunction

  // Result checker: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("max_val", 32'(max_val), 32'(e.v));
        check("max_idx", 32'(max_idx), 32'(e.i));
        check("empty",   32'(empty),   32'(e.e));
`ifdef MIN_TRACK_EN
        check("min_val", 32'(min_val), 32'(e.mn));
        check("min_idx", 32'(min_idx), 32'(e.mi));
`endif
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en   = 1'b0;
    mdl[a]  = 8'(d);
  endtask

  task automatic scan(input int n, input bit disturb, input bit wrs, input int wa, input int wd);
    int   cnt;
    int   busyc;
    int   ne;
    exp_t e;
    ne = (n > DEPTH) ? DEPTH : n;
    @(negedge clk);
    if (wrs) begin
      wr_en   = 1'b1;
      wr_addr = AW'(wa);
      wr_data = 8'(wd);
      mdl[wa] = 8'(wd);
    end
    e = model(n);
    sb.push_back(e);
    start = 1'b1;
    len   = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    cnt   = 1;
    busyc = 0;
    while (!done && cnt < 40) begin
      if (busy) busyc++;
      if (disturb && cnt == 2) begin
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'd255;
        start   = 1'b1;
        len     = 4'd1;
      end
      if (disturb && cnt == 3) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), 32'(ne + 1));
    check("busy_cycles", 32'(busyc), 32'(ne));
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("hold_max_val", 32'(max_val), 32'(e.v));
  endtask

  initial begin
    int dcount;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_empty",   32'(empty),   32'd0);
    check("rst_max_val", 32'(max_val), 32'd0);
    check("rst_max_idx", 32'(max_idx), 32'd0);

    // Basic scan with a tie on 9: last index wins.
    wr(0, 3); wr(1, 9); wr(2, 4); wr(3, 9); wr(4, 1);
    scan(5, 0, 0, 0, 0);

    // Empty scan, then a single-entry scan clears empty.
    scan(0, 0, 0, 0, 0);
    wr(0, 7);
    scan(1, 0, 0, 0, 0);

    // Over-length clamps to DEPTH.
    wr(7, 200);
    scan(15, 0, 0, 0, 0);

    // Write and start during SCAN are dropped.
    scan(5, 1, 0, 0, 0);
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("no_queued_start", 32'(dcount), 32'd0);
    scan(8, 0, 0, 0, 0);

    // Write on the start edge is seen by the scan.
    scan(2, 0, 1, 1, 250);

    // Reset in the second SCAN cycle aborts the scan.
    @(negedge clk);
    start = 1'b1;
    len   = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_done",    32'(done),    32'd0);
    check("abort_max_val", 32'(max_val), 32'd0);
    check("abort_max_idx", 32'(max_idx), 32'd0);
    check("abort_empty",   32'(empty),   32'd0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    scan(8, 0, 0, 0, 0);

    // Min/max mixed example.
    wr(0, 5); wr(1, 2); wr(2, 8); wr(3, 2);
    scan(4, 0, 0, 0, 0);

    // Random contents with a narrow range to provoke ties.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 7)));
      scan(int'($urandom_range(0, 15)), 0, 0, 0, 0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
